// File: rtl/add_arb_pkg.sv
// Shared constants and types for the adder-sharing arbiter.
// Build option ADD_ARB_FIXED_PRIO_EN (see add_share_arbiter) does not affect this package.
package add_arb_pkg;
  localparam int ADD_OP_W  = 6;
  localparam int ADD_RES_W = 8;
  localparam int ADD_LAT   = 4;
  localparam int ID_W_MAX  = 3;  // enough for up to 8 requesters

  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [ID_W_MAX-1:0]  id;
    logic [ADD_RES_W-1:0] y;
  } rsp_t;

  // Index 'k' steps after 'base', wrapping at n.
  function automatic int rr_idx(input int base, input int k, input int n);
    int s;
    s = base + k;
    return (s >= n) ? s - n : s;
  endfunction
endpackage

// File: rtl/add_arb_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and a head taken
// straight from the storage flops (no bypass from push to head).
module add_arb_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign empty     = (r_wr == r_rd);
  assign full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign rdata     = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/add_share_arbiter.sv
// Shares one fixed-latency 4-operand adder among NREQ requesters with credit-limited issue.
// Define ADD_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration (default: round-robin).
module add_share_arbiter
  import add_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int LAT        = ADD_LAT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*ADD_OP_W-1:0]     req_a,
  input  logic [NREQ*ADD_OP_W-1:0]     req_b,
  input  logic [NREQ*ADD_OP_W-1:0]     req_c,
  input  logic [NREQ*ADD_OP_W-1:0]     req_d,
  output logic [ADD_OP_W-1:0]          add_a,
  output logic [ADD_OP_W-1:0]          add_b,
  output logic [ADD_OP_W-1:0]          add_c,
  output logic [ADD_OP_W-1:0]          add_d,
  input  logic [ADD_RES_W-1:0]         add_y,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NREQ)-1:0]      rsp_id,
  output logic [ADD_RES_W-1:0]         rsp_y,
  output logic                         busy
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0] r_cnt;
  tag_t             r_tag [LAT];
  logic             w_issue;
  logic [ID_W-1:0]  w_gidx;
  logic             w_pop;
  logic             w_fifo_push;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  rsp_t             w_wr;
  rsp_t             w_head;
  logic             w_unused_id;

`ifndef ADD_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]  r_ptr;
`endif

  // Arbitration: descending scan so the highest-priority candidate is written last.
  always_comb begin
    w_issue = 1'b0;
    w_gidx  = '0;
    if (!rst && (r_cnt < CNT_W'(FIFO_DEPTH))) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef ADD_ARB_FIXED_PRIO_EN
        if (req_valid[k]) begin
          w_issue = 1'b1;
          w_gidx  = ID_W'(k);
        end
`else
        if (req_valid[rr_idx(int'(r_ptr), k, NREQ)]) begin
          w_issue = 1'b1;
          w_gidx  = ID_W'(rr_idx(int'(r_ptr), k, NREQ));
        end
`endif
      end
    end
  end

  assign req_ready = w_issue ? (NREQ'(1) << w_gidx) : '0;
  assign add_a     = w_issue ? req_a[int'(w_gidx)*ADD_OP_W +: ADD_OP_W] : '0;
  assign add_b     = w_issue ? req_b[int'(w_gidx)*ADD_OP_W +: ADD_OP_W] : '0;
  assign add_c     = w_issue ? req_c[int'(w_gidx)*ADD_OP_W +: ADD_OP_W] : '0;
  assign add_d     = w_issue ? req_d[int'(w_gidx)*ADD_OP_W +: ADD_OP_W] : '0;

`ifndef ADD_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst)          r_ptr <= '0;
    else if (w_issue) r_ptr <= ID_W'(rr_idx(int'(w_gidx), 1, NREQ));
  end
`endif

  // Tag pipeline mirrors the adder latency; it never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0].valid <= w_issue;
      r_tag[0].id    <= ID_W_MAX'(w_gidx);
      for (int s = 1; s < LAT; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  assign w_fifo_push = r_tag[LAT-1].valid;
  assign w_wr.id     = r_tag[LAT-1].id;
  assign w_wr.y      = add_y;

  add_arb_fifo #(
    .WIDTH($bits(rsp_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_fifo_push),
    .wdata (w_wr),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign rsp_valid   = !rst && !w_fifo_empty;
  assign w_pop       = rsp_valid && rsp_ready;
  assign rsp_id      = rsp_valid ? w_head.id[ID_W-1:0] : '0;
  assign rsp_y       = rsp_valid ? w_head.y : '0;
  assign w_unused_id = ^w_head.id;

  // Credits cover both in-flight tags and buffered responses.
  always_ff @(posedge clk) begin
    if (rst)                  r_cnt <= '0;
    else if (w_issue && !w_pop) r_cnt <= r_cnt + CNT_W'(1);
    else if (!w_issue && w_pop) r_cnt <= r_cnt - CNT_W'(1);
  end

  assign busy = !rst && (r_cnt != '0);
endmodule
